multicycle_control: RTL

Control FSM sequencing a multicycle version of the 16-bit MIPS datapath: register file, 16-bit ALU, shared instruction/data memory and the PC/IR/ALUOut registers. It decodes the 4-bit opcode and drives per-state datapath strobes. It handshakes with a memory that may insert wait states, counts retired instructions and halts on an illegal opcode or a memory timeout.

---
 rtl/multicycle_control.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle 16-bit MIPS-style datapath.
// Sequences fetch/decode/execute/writeback, drives the datapath strobes and
// selects, handshakes with a wait-state memory, counts retired instructions
// and halts on an undefined opcode or a memory wait overrun.
module multicycle_control #(
  parameter int WAIT_LIMIT = 15,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [3:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_ctrl,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count,
  output logic               illegal,
  output logic               timeout
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  // Opcodes
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operand B selects
  localparam logic [1:0] B_REG   = 2'b00;
  localparam logic [1:0] B_TWO   = 2'b01;
  localparam logic [1:0] B_SEXT  = 2'b10;
  localparam logic [1:0] B_SEXT2 = 2'b11;

  // Wait count at which a still-stalled access gives up: the access has then
  // spent WAIT_LIMIT cycles with mem_ready low.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t             state_q, state_d;
  logic [7:0]         wait_q, wait_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic               retire;

  // Raw strobes before reset gating
  logic mem_req_s, mem_we_s, ir_write_s, pc_write_s, reg_write_s;

  // State, wait counter, retirement counter and sticky halt flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, wait/timeout tracking and per-state datapath controls
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    retire      = 1'b0;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    reg_write_s = 1'b0;
    i_or_d      = 1'b0;
    pc_src      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = B_REG;
    alu_ctrl    = ALU_AND;

    case (state_q)
      S_FETCH: begin
        // PC + 2 computed alongside the instruction read
        mem_req_s = run;
        alu_src_b = B_TWO;
        alu_ctrl  = ALU_ADD;
        if (run) begin
          if (mem_ready) begin
            ir_write_s = 1'b1;
            pc_write_s = 1'b1;
            state_d    = S_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end

      S_DECODE: begin
        // Branch target PC + (sext << 1) lands in ALUOut for a possible BRANCH
        alu_src_b = B_SEXT2;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: state_d = S_EXEC_R;
          OP_ADDI:                               state_d = S_EXEC_I;
          OP_LW, OP_SW:                          state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                        state_d = S_BRANCH;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = B_REG;
        case (opcode)
          OP_SUB:  alu_ctrl = ALU_SUB;
          OP_AND:  alu_ctrl = ALU_AND;
          OP_OR:   alu_ctrl = ALU_OR;
          OP_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
        state_d = S_R_WB;
      end

      S_R_WB: begin
        reg_write_s = 1'b1;
        reg_dst     = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = B_SEXT;
        alu_ctrl  = ALU_ADD;
        state_d   = S_I_WB;
      end

      S_I_WB: begin
        reg_write_s = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = B_SEXT;
        alu_ctrl  = ALU_ADD;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_req_s = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_MEM_WB: begin
        reg_write_s = 1'b1;
        mem_to_reg  = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end

      S_MEM_WR: begin
        // A store only retires when the memory accepts it
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = B_REG;
        alu_ctrl   = ALU_SUB;
        pc_src     = 1'b1;
        pc_write_s = ((opcode == OP_BEQ) &&  zero) ||
                     ((opcode == OP_BNE) && !zero);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        // Unused encodings recover to a clean fetch
        state_d = S_FETCH;
      end
    endcase
  end

  // Retired-instruction counter, free-running wrap
  always_comb begin
    count_d = count_q;
    if (retire) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // Strobes are masked while reset is asserted so an in-flight access is
  // abandoned immediately rather than at the next clock edge.
  assign mem_req     = mem_req_s   & rst_n;
  assign mem_we      = mem_we_s    & rst_n;
  assign ir_write    = ir_write_s  & rst_n;
  assign pc_write    = pc_write_s  & rst_n;
  assign reg_write   = reg_write_s & rst_n;

  assign state       = state_q;
  assign instr_count = count_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;

endmodule
